// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-ported memory between the IF and MEM stages.
// Each grant holds the memory for LATENCY busy cycles, then pulses the requester's ack for one cycle.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [2:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        ACK_I  = 3'd3,
        ACK_D  = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ack;
    logic              r_d_ack;

    // Handshake: a req is a level held until its ack; the ack is a single-cycle pulse
    // in the ACK state, where no new grant is made so the held req is never re-served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Data port wins: it belongs to the older instruction.
                    if (d_req) begin
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_wr    <= d_wr;
                        r_mem_en    <= 1'b1;
                        r_cnt       <= CNT_LOAD;
                        r_state     <= BUSY_D;
                    end else if (i_req) begin
                        r_mem_addr <= i_addr;
                        r_mem_wr   <= 1'b0;
                        r_mem_en   <= 1'b1;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_mem_en <= 1'b0;
                        if (r_state == BUSY_I) begin
                            r_i_rdata <= mem_rdata;
                            r_i_ack   <= 1'b1;
                            r_state   <= ACK_I;
                        end else begin
                            r_d_rdata <= mem_rdata;
                            r_d_ack   <= 1'b1;
                            r_state   <= ACK_D;
                        end
                    end
                end
                ACK_I, ACK_D: r_state <= IDLE;
                default:      r_state <= IDLE;
            endcase
        end
    end

    assign i_rdata     = r_i_rdata;
    assign i_ack       = r_i_ack;
    assign d_rdata     = r_d_rdata;
    assign d_ack       = r_d_ack;
    assign mem_en      = r_mem_en;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign stall_if    = i_req & ~r_i_ack;
    assign stall_mem   = d_req & ~r_d_ack;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 instance for back-to-back single-cycle accesses.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    // LATENCY=4 instance signals
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_wr, stall_if, stall_mem;
    logic [2:0]  dbg_state;
    logic [15:0] rd_val;
    int          bcnt;

    // LATENCY=1 instance signals
    logic        b_i_req, b_d_req, b_d_wr;
    logic [15:0] b_i_addr, b_d_addr, b_d_wdata;
    logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_i_ack, b_d_ack, b_mem_en, b_mem_wr, b_stall_if, b_stall_mem;
    logic [2:0]  b_dbg_state;

    int n_chk;
    int n_fail;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .o_dbg_state(dbg_state)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem), .o_dbg_state(b_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is only valid in the 4th consecutive busy cycle.
    always @(posedge clk) begin
        if (mem_en) bcnt <= bcnt + 1;
        else        bcnt <= 0;
    end
    assign mem_rdata   = (mem_en && bcnt == 3) ? rd_val : 16'hDEAD;
    assign b_mem_rdata = b_mem_en ? (b_mem_addr ^ 16'h5A5A) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        b_i_req = 1'b0; b_d_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; bcnt = 0;
        rd_val = 16'h0000;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; d_wr = 1'b0;
        b_i_addr = 16'h0; b_d_addr = 16'h0; b_d_wdata = 16'h0; b_d_wr = 1'b0;
        b_i_req = 1'b0; b_d_req = 1'b0;

        // 1: reset with both requests high
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1;
        d_addr = 16'h0033; d_wdata = 16'h7777; d_wr = 1'b1; i_addr = 16'h0011;
        tick(); tick();
        check("rst_mem_en",    {31'd0, mem_en}, 32'd0);
        check("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_acks",      {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_rdata",     {i_rdata, d_rdata}, 32'd0);
        check("rst_state",     {29'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_state_busy_d", {29'd0, dbg_state}, 32'd2);
        check("rel_mem_addr",     {16'd0, mem_addr}, 32'h0033);
        check("rel_mem_wr",       {31'd0, mem_wr}, 32'd1);
        do_reset();

        // 2: fetch only
        i_addr = 16'h0040; rd_val = 16'hA5C3; i_req = 1'b1; d_wr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("f_en_c%0d", c),    {31'd0, mem_en}, 32'd1);
            check($sformatf("f_addr_c%0d", c),  {16'd0, mem_addr}, 32'h0040);
            check($sformatf("f_wr_c%0d", c),    {31'd0, mem_wr}, 32'd0);
            check($sformatf("f_stall_c%0d", c), {31'd0, stall_if}, 32'd1);
            check($sformatf("f_ack_c%0d", c),   {31'd0, i_ack}, 32'd0);
        end
        tick();
        check("f_ack_c5",   {31'd0, i_ack}, 32'd1);
        check("f_rdata_c5", {16'd0, i_rdata}, 32'hA5C3);
        check("f_en_c5",    {31'd0, mem_en}, 32'd0);
        check("f_stall_c5", {31'd0, stall_if}, 32'd0);
        i_req = 1'b0;
        tick();
        check("f_ack_c6", {31'd0, i_ack}, 32'd0);
        check("f_idle_c6", {29'd0, dbg_state}, 32'd0);

        // 3: simultaneous store and fetch; store first
        i_req = 1'b1; i_addr = 16'h0044;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        rd_val = 16'h0F0F;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("s_en_c%0d", c),     {31'd0, mem_en}, 32'd1);
            check($sformatf("s_wr_c%0d", c),     {31'd0, mem_wr}, 32'd1);
            check($sformatf("s_addr_c%0d", c),   {16'd0, mem_addr}, 32'h0100);
            check($sformatf("s_wdata_c%0d", c),  {16'd0, mem_wdata}, 32'hBEEF);
            check($sformatf("s_stalls_c%0d", c), {30'd0, stall_if, stall_mem}, 32'd3);
        end
        tick();
        check("s_dack_c5",  {30'd0, d_ack, i_ack}, 32'd2);
        check("s_stall_c5", {30'd0, stall_if, stall_mem}, 32'd2);
        d_req = 1'b0; rd_val = 16'h1357;
        tick();
        check("s_idle_c6", {30'd0, mem_en, stall_if}, 32'd1);
        for (int c = 7; c <= 10; c++) begin
            tick();
            check($sformatf("s_fen_c%0d", c),    {31'd0, mem_en}, 32'd1);
            check($sformatf("s_faddr_c%0d", c),  {16'd0, mem_addr}, 32'h0044);
            check($sformatf("s_fwr_c%0d", c),    {31'd0, mem_wr}, 32'd0);
            check($sformatf("s_fstall_c%0d", c), {31'd0, stall_if}, 32'd1);
        end
        tick();
        check("s_iack_c11",   {31'd0, i_ack}, 32'd1);
        check("s_irdata_c11", {16'd0, i_rdata}, 32'h1357);
        i_req = 1'b0;
        tick();

        // 4: load with d_req held through the ack cycle
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0002; rd_val = 16'h1234;
        for (int c = 1; c <= 4; c++) tick();
        check("l_en_c4", {31'd0, mem_en}, 32'd1);
        tick();
        check("l_dack_c5",  {31'd0, d_ack}, 32'd1);
        check("l_rdata_c5", {16'd0, d_rdata}, 32'h1234);
        tick();
        check("l_dack_c6", {31'd0, d_ack}, 32'd0);
        check("l_en_c6",   {31'd0, mem_en}, 32'd0);
        check("l_idle_c6", {29'd0, dbg_state}, 32'd0);
        d_req = 1'b0;
        tick();
        check("l_en_c7", {31'd0, mem_en}, 32'd0);

        // 5: reset in the 2nd busy cycle, then full restart of the pending load
        d_req = 1'b1; d_addr = 16'h0007; rd_val = 16'h7777;
        tick(); tick();
        check("r_en_busy2", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("r_en_in_rst",    {31'd0, mem_en}, 32'd0);
        check("r_acks_in_rst",  {30'd0, i_ack, d_ack}, 32'd0);
        check("r_state_in_rst", {29'd0, dbg_state}, 32'd0);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("r_en_c%0d", c),   {31'd0, mem_en}, 32'd1);
            check($sformatf("r_dack_c%0d", c), {31'd0, d_ack}, 32'd0);
        end
        tick();
        check("r_dack_c5",  {31'd0, d_ack}, 32'd1);
        check("r_rdata_c5", {16'd0, d_rdata}, 32'h7777);
        d_req = 1'b0;
        tick();

        // 6: LATENCY=1 back-to-back fetches
        b_i_req = 1'b1; b_i_addr = 16'h0000;
        tick();
        check("b_en_c1",   {31'd0, b_mem_en}, 32'd1);
        check("b_addr_c1", {16'd0, b_mem_addr}, 32'h0000);
        tick();
        check("b_ack_c2",   {31'd0, b_i_ack}, 32'd1);
        check("b_rdata_c2", {16'd0, b_i_rdata}, 32'h5A5A);
        check("b_en_c2",    {31'd0, b_mem_en}, 32'd0);
        b_i_addr = 16'h0001;
        tick();
        check("b_idle_c3", {30'd0, b_mem_en, b_i_ack}, 32'd0);
        tick();
        check("b_en_c4",   {31'd0, b_mem_en}, 32'd1);
        check("b_addr_c4", {16'd0, b_mem_addr}, 32'h0001);
        tick();
        check("b_ack_c5",   {31'd0, b_i_ack}, 32'd1);
        check("b_rdata_c5", {16'd0, b_i_rdata}, 32'h5A5B);
        b_i_req = 1'b0;
        tick();
        check("b_ack_c6", {31'd0, b_i_ack}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
